// File: rtl/hamming_ecc_decoder.sv
// Hamming(7,4) single-error-correcting decoder.
// Two-stage valid/ready pipeline with a saturating corrected-word counter.
module hamming_ecc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data,
  output logic [2:0]       syndrome,
  output logic             corrected,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  logic       s1_valid;
  logic [6:0] s1_cw;
  logic [2:0] s1_syn;
  logic [2:0] syn_in;
  logic [6:0] flip;
  logic [6:0] fixed;
  logic       adv2;
  logic       out_hs;

  assign syn_in[0] = codeword[6] ^ codeword[4] ^ codeword[2] ^ codeword[0];
  assign syn_in[1] = codeword[5] ^ codeword[4] ^ codeword[1] ^ codeword[0];
  assign syn_in[2] = codeword[3] ^ codeword[2] ^ codeword[1] ^ codeword[0];

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign out_hs   = out_valid && out_ready;

  // Position s maps to codeword bit 7-s; build the single-bit flip mask.
  always_comb begin
    flip = 7'b0000000;
    unique case (s1_syn)
      3'd1:    flip = 7'b1000000;
      3'd2:    flip = 7'b0100000;
      3'd3:    flip = 7'b0010000;
      3'd4:    flip = 7'b0001000;
      3'd5:    flip = 7'b0000100;
      3'd6:    flip = 7'b0000010;
      3'd7:    flip = 7'b0000001;
      default: flip = 7'b0000000;
    endcase
  end

  assign fixed = s1_cw ^ flip;

  // Stage 1: capture the received word and its syndrome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= codeword;
        s1_syn <= syn_in;
      end
    end
  end

  // Stage 2: corrected nibble, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data      <= '0;
      syndrome  <= '0;
      corrected <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data      <= {fixed[0], fixed[1], fixed[2], fixed[4]};
        syndrome  <= s1_syn;
        corrected <= |s1_syn;
      end
    end
  end

  // Count corrected words as they leave; clear has priority, no wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (out_hs && corrected && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_ecc_decoder.sv
// Directed bench for hamming_ecc_decoder.
// Uses a 2-bit counter so saturation is reachable.
module tb_hamming_ecc_decoder;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    codeword;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    data;
  logic [2:0]    syndrome;
  logic          corrected;
  logic          clr_count;
  logic [CW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] mon_q[$];

  hamming_ecc_decoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeword  (codeword),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data),
    .syndrome  (syndrome),
    .corrected (corrected),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Record every delivered nibble in handshake order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) mon_q.push_back(data);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run1(input string tag, input logic [6:0] cw,
                      input logic [3:0] ed, input logic [2:0] es,
                      input logic ec);
    in_valid  = 1'b1;
    codeword  = cw;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_v0"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_v1"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(data), 32'(ed));
    chk({tag, "_syn"}, 32'(syndrome), 32'(es));
    chk({tag, "_cor"}, 32'(corrected), 32'(ec));
    @(posedge clk); #1;
    chk({tag, "_gone"}, 32'(out_valid), 32'd0);
  endtask

  logic [6:0] sw[4];
  logic [3:0] sd[4];
  int         acc_i;
  logic       acc;

  initial begin
    sw[0] = 7'b1010101; sd[0] = 4'b1011;
    sw[1] = 7'b0000000; sd[1] = 4'b0000;
    sw[2] = 7'b1111111; sd[2] = 4'b1111;
    sw[3] = 7'b1110000; sd[3] = 4'b0001;

    rst       = 1'b1;
    in_valid  = 1'b0;
    codeword  = '0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    chk("rst_dat", 32'(data), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);

    run1("clean", 7'b1010101, 4'b1011, 3'd0, 1'b0);
    chk("clean_cnt", 32'(err_count), 32'd0);
    run1("d0err", 7'b1000101, 4'b1011, 3'd3, 1'b1);
    chk("d0err_cnt", 32'(err_count), 32'd1);
    run1("p1err", 7'b0010101, 4'b1011, 3'd1, 1'b1);
    chk("p1err_cnt", 32'(err_count), 32'd2);
    run1("zero", 7'b0000000, 4'b0000, 3'd0, 1'b0);
    run1("ones", 7'b1111111, 4'b1111, 3'd0, 1'b0);
    run1("dbl", 7'b0110101, 4'b1010, 3'd3, 1'b1);
    chk("dbl_cnt", 32'(err_count), 32'd3);
    run1("d3err", 7'b1010100, 4'b1011, 3'd7, 1'b1);
    run1("p3err", 7'b1011101, 4'b1011, 3'd4, 1'b1);
    chk("sat_cnt", 32'(err_count), 32'd3);

    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clr_cnt", 32'(err_count), 32'd0);
    run1("c1", 7'b1000101, 4'b1011, 3'd3, 1'b1);
    chk("c1_cnt", 32'(err_count), 32'd1);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    codeword  = 7'b0010101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clrhs_ov", 32'(out_valid), 32'd1);
    chk("clrhs_cor", 32'(corrected), 32'd1);
    clr_count = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("clrhs_cnt", 32'(err_count), 32'd0);
    chk("clrhs_ov0", 32'(out_valid), 32'd0);

    mon_q.delete();
    acc_i = 0;
    for (int st = 0; st < 20; st++) begin
      out_ready = !(st >= 2 && st <= 4);
      in_valid  = (acc_i < 4);
      codeword  = sw[(acc_i < 4) ? acc_i : 0];
      #1;
      if (st == 2) chk("strm_rdy0", 32'(in_ready), 32'd0);
      if (st >= 2 && st <= 4) begin
        chk("strm_hold_v", 32'(out_valid), 32'd1);
        chk("strm_hold_d", 32'(data), 32'(sd[0]));
        chk("strm_hold_s", 32'(syndrome), 32'd0);
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) acc_i++;
    end
    in_valid = 1'b0;
    chk("strm_acc", 32'(acc_i), 32'd4);
    chk("strm_n", 32'(mon_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < mon_q.size())
        chk("strm_ord", 32'(mon_q[k]), 32'(sd[k]));
    end

    run1("r1", 7'b1000101, 4'b1011, 3'd3, 1'b1);
    chk("r1_cnt", 32'(err_count), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    codeword  = 7'b1010101;
    @(posedge clk); #1;
    codeword = 7'b0000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("full_ov", 32'(out_valid), 32'd1);
    chk("full_rdy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_cnt", 32'(err_count), 32'd0);
    chk("arst_dat", 32'(data), 32'd0);
    chk("arst_cor", 32'(corrected), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_q.delete();
    #1;
    chk("post_rdy", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("post_stale", 32'(mon_q.size()), 32'd0);
    chk("post_ov", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_ecc_decoder.md
HAMMING_ECC_DECODER -- requirements
Module: hamming_ecc_decoder

Interface
REQ-001 Parameter CNT_W, default 16, width of the corrected-error counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 in_valid  input  1  codeword is present on codeword.
REQ-005 in_ready  output  1  decoder accepts a codeword this cycle.
REQ-006 codeword  input  7  Hamming(7,4) word; bit 6 = position 1 ... bit 0 = position 7.
REQ-007 out_valid  output  1  decoded result is present on data/syndrome/corrected.
REQ-008 out_ready  input  1  downstream accepts the result this cycle.
REQ-009 data  output  4  corrected data nibble, same bit order as the encoder's data input.
REQ-010 syndrome  output  3  syndrome of the received word (0 = no error).
REQ-011 corrected  output  1  high when syndrome is nonzero and one bit was flipped.
REQ-012 clr_count  input  1  synchronous clear of err_count.
REQ-013 err_count  output  CNT_W  saturating count of corrected words delivered.

Function
REQ-014 Bit map: p1=cw[6], p2=cw[5], d0=cw[4], p3=cw[3], d1=cw[2], d2=cw[1], d3=cw[0].
REQ-015 Syndrome: s[0]=cw6^cw4^cw2^cw0; s[1]=cw5^cw4^cw1^cw0; s[2]=cw3^cw2^cw1^cw0.
REQ-016 Nonzero s identifies the erroneous position s (1..7), i.e. codeword bit index 7-s; that bit SHALL be inverted before extracting data.
REQ-017 Parity-position errors (s = 1, 2, 4) SHALL leave data unchanged and still assert corrected.
REQ-018 Double-bit errors are not detected; the decoder SHALL apply the single-bit rule regardless.
REQ-019 Two-stage pipeline: stage 1 registers codeword and syndrome; stage 2 registers data, syndrome, corrected and out_valid.
REQ-020 Input handshake completes when in_valid && in_ready; output handshake completes when out_valid && out_ready.
REQ-021 Stage 2 advances when !out_valid || out_ready; in_ready = !s1_valid || stage-2 advance (combinational, no dependency on in_valid).
REQ-022 Latency: accepted in cycle N, result has out_valid high from cycle N+2 when no backpressure.
REQ-023 Throughput: one word per cycle with out_ready held high.
REQ-024 While out_valid && !out_ready, data/syndrome/corrected SHALL be held stable; no word dropped, duplicated or reordered.
REQ-025 With stage 1 and stage 2 both full and out_ready low, in_ready SHALL be low.
REQ-026 err_count increments by 1 on each output handshake with corrected=1.
REQ-027 err_count saturates at 2^CNT_W-1; no wrap-around.
REQ-028 clr_count high SHALL set err_count to 0 next edge; clear wins over a simultaneous increment.

Reset
REQ-029 rst asserted SHALL immediately force in-flight valid flags low, out_valid=0, data=0, syndrome=0, corrected=0, err_count=0.
REQ-030 in_ready SHALL be 1 whenever rst is deasserted and both stages are empty, including the first cycle after reset.
REQ-031 Reset mid-stream SHALL discard all in-flight words; no result for them appears after reset.

Verification
REQ-032 data 4'b1011 clean, codeword 7'b1010101 -> 2 cycles later data=4'b1011, syndrome=0, corrected=0, err_count unchanged.
REQ-033 Codeword 7'b1000101 (cw[4] flipped) -> data=4'b1011, syndrome=3, corrected=1, err_count +1.
REQ-034 Codeword 7'b0010101 (p1 flipped) -> data=4'b1011, syndrome=1, corrected=1.
REQ-035 Stream 4 words back-to-back with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 are buffered, outputs held, all 4 delivered in order.
REQ-036 CNT_W=2, deliver 5 corrected words -> err_count sticks at 3; clr_count pulse coincident with a corrected handshake -> err_count=0.
REQ-037 Assert rst with both stages full -> out_valid=0 immediately, err_count=0, no stale output after release.
